reg_bank_arbiter: RTL and testbench

//   Shares one bank of D-flip-flop storage registers between NREQ write requesters.

---
 rtl/reg_bank_arbiter.sv | 178 +++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one register bank.
// Each granted write takes three cycles (IDLE -> GRANT -> WRITE); reads are combinational.
module reg_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                    Clk,
    input  logic                    Resetn,
    input  logic [NREQ-1:0]         Req,
    input  logic [NREQ*AW-1:0]      WrAddr,
    input  logic [NREQ*WIDTH-1:0]   WrData,
    output logic [NREQ-1:0]         Grant,
    output logic [NREQ-1:0]         Ack,
    output logic                    Busy,
    input  logic [AW-1:0]           RdAddr,
    output logic [WIDTH-1:0]        RdData
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [AW-1:0]      hold_addr_q, hold_addr_d;
    logic [WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [WIDTH-1:0]   bank_q [DEPTH];

    logic               win_found_s;
    logic [PW-1:0]      win_idx_s;
    logic [PW-1:0]      cand_s;
    logic [NREQ-1:0]    ack_s;
    logic               busy_s;
    logic               commit_s;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = {NREQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Winner search: first asserted request starting at the round-robin pointer
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {PW{1'b0}};
        cand_s      = {PW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found_s && Req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a withdrawn request in GRANT aborts the transaction
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) state_d = ST_GRANT;
                else             state_d = ST_IDLE;
            end
            ST_GRANT: begin
                if (Req[owner_q]) state_d = ST_WRITE;
                else              state_d = ST_IDLE;
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        ack_s    = {NREQ{1'b0}};
        busy_s   = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE:  busy_s = 1'b0;
            ST_GRANT: busy_s = 1'b1;
            ST_WRITE: begin
                busy_s   = 1'b1;
                commit_s = 1'b1;
                ack_s    = onehot(owner_q);
            end
            default:  busy_s = 1'b0;
        endcase
    end

    // Datapath next-state: owner/grant selection, operand capture, pointer advance
    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    owner_d = win_idx_s;
                    grant_d = onehot(win_idx_s);
                end else begin
                    grant_d = {NREQ{1'b0}};
                end
            end
            ST_GRANT: begin
                if (Req[owner_q]) begin
                    hold_addr_d = WrAddr[owner_q*AW +: AW];
                    hold_data_d = WrData[owner_q*WIDTH +: WIDTH];
                end else begin
                    grant_d = {NREQ{1'b0}};
                end
            end
            ST_WRITE: begin
                grant_d = {NREQ{1'b0}};
                if (owner_q == PW'(NREQ - 1)) ptr_d = {PW{1'b0}};
                else                          ptr_d = owner_q + PW'(1);
            end
            default: grant_d = {NREQ{1'b0}};
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ptr_q       <= {PW{1'b0}};
            owner_q     <= {PW{1'b0}};
            grant_q     <= {NREQ{1'b0}};
            hold_addr_q <= {AW{1'b0}};
            hold_data_q <= {WIDTH{1'b0}};
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Storage bank; only the WRITE state commits
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= {WIDTH{1'b0}};
            end
        end else if (commit_s) begin
            bank_q[hold_addr_q] <= hold_data_q;
        end else begin
            bank_q[hold_addr_q] <= bank_q[hold_addr_q];
        end
    end

    assign Grant  = grant_q;
    assign Ack    = ack_s;
    assign Busy   = busy_s;
    assign RdData = bank_q[RdAddr];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single write, round-robin order,
// pointer priority, aborted grants and reset during a write.
module tb_reg_bank_arbiter;

    logic        Clk;
    logic        Resetn;
    logic [3:0]  Req;
    logic [11:0] WrAddr;
    logic [31:0] WrData;
    logic [3:0]  Grant;
    logic [3:0]  Ack;
    logic        Busy;
    logic [2:0]  RdAddr;
    logic [7:0]  RdData;

    int vectors;
    int miscompares;

    reg_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(8), .AW(3)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .Req    (Req),
        .WrAddr (WrAddr),
        .WrData (WrData),
        .Grant  (Grant),
        .Ack    (Ack),
        .Busy   (Busy),
        .RdAddr (RdAddr),
        .RdData (RdData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic [2:0] a, input logic [7:0] d);
        WrAddr[i*3 +: 3] = a;
        WrData[i*8 +: 8] = d;
    endtask

    task automatic apply_reset();
        Req    = 4'b0000;
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (Grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b expected %b", Grant, 4'b0000); end
        vectors++; if (Ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b expected %b", Ack, 4'b0000); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected %b", Busy, 1'b0); end
        for (int a = 0; a < 8; a++) begin
            RdAddr = 3'(a);
            #1;
            vectors++; if (RdData !== 8'h00) begin miscompares++; $display("FAIL reset_bank[%0d]: got %h expected %h", a, RdData, 8'h00); end
        end
    endtask

    task automatic test_single_write();
        set_fields(2, 3'd5, 8'hA5);
        RdAddr = 3'd5;
        Req = 4'b0100;
        tick(); // E0
        vectors++; if (Grant !== 4'b0100) begin miscompares++; $display("FAIL t2_grant_e0: got %b expected %b", Grant, 4'b0100); end
        vectors++; if (Ack !== 4'b0000) begin miscompares++; $display("FAIL t2_ack_e0: got %b expected %b", Ack, 4'b0000); end
        vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL t2_busy_e0: got %b expected %b", Busy, 1'b1); end
        tick(); // E1
        vectors++; if (Ack !== 4'b0100) begin miscompares++; $display("FAIL t2_ack_e1: got %b expected %b", Ack, 4'b0100); end
        vectors++; if (RdData !== 8'h00) begin miscompares++; $display("FAIL t2_old_read: got %h expected %h", RdData, 8'h00); end
        Req = 4'b0000;
        tick(); // E2
        vectors++; if (Ack !== 4'b0000) begin miscompares++; $display("FAIL t2_ack_e2: got %b expected %b", Ack, 4'b0000); end
        vectors++; if (RdData !== 8'hA5) begin miscompares++; $display("FAIL t2_read: got %h expected %h", RdData, 8'hA5); end
        vectors++; if (Grant !== 4'b0000) begin miscompares++; $display("FAIL t2_grant_e2: got %b expected %b", Grant, 4'b0000); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL t2_busy_e2: got %b expected %b", Busy, 1'b0); end
    endtask

    task automatic test_round_robin();
        int n;
        int last;
        logic [3:0] exp_ack;
        apply_reset();
        for (int i = 0; i < 4; i++) set_fields(i, 3'(i), 8'h10 + 8'(i));
        Req  = 4'b1111;
        n    = 0;
        last = -1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            tick();
            if (Ack !== 4'b0000) begin
                exp_ack = 4'b0001 << n;
                vectors++; if (Ack !== exp_ack) begin miscompares++; $display("FAIL t3_ack_order[%0d]: got %b expected %b", n, Ack, exp_ack); end
                if (n == 0) begin
                    vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL t3_first_ack_cycle: got %0d expected %0d", cyc, 1); end
                end else begin
                    vectors++; if (cyc - last !== 3) begin miscompares++; $display("FAIL t3_ack_spacing[%0d]: got %0d expected %0d", n, cyc - last, 3); end
                end
                last = cyc;
                Req  = Req & ~Ack;
                n++;
            end
        end
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL t3_ack_count: got %0d expected %0d", n, 4); end
        Req = 4'b0000;
        tick();
        for (int a = 0; a < 4; a++) begin
            RdAddr = 3'(a);
            #1;
            vectors++; if (RdData !== 8'h10 + 8'(a)) begin miscompares++; $display("FAIL t3_bank[%0d]: got %h expected %h", a, RdData, 8'h10 + 8'(a)); end
        end
    endtask

    task automatic test_priority();
        set_fields(1, 3'd6, 8'h66);
        Req = 4'b0010;
        tick();
        vectors++; if (Grant !== 4'b0010) begin miscompares++; $display("FAIL t4_solo_grant: got %b expected %b", Grant, 4'b0010); end
        tick();
        vectors++; if (Ack !== 4'b0010) begin miscompares++; $display("FAIL t4_solo_ack: got %b expected %b", Ack, 4'b0010); end
        Req = 4'b0000;
        tick();
        set_fields(0, 3'd4, 8'h44);
        set_fields(1, 3'd6, 8'h77);
        Req = 4'b0011;
        tick();
        vectors++; if (Grant !== 4'b0001) begin miscompares++; $display("FAIL t4_first_grant: got %b expected %b", Grant, 4'b0001); end
        tick();
        vectors++; if (Ack !== 4'b0001) begin miscompares++; $display("FAIL t4_first_ack: got %b expected %b", Ack, 4'b0001); end
        Req = 4'b0010;
        tick();
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL t4_idle_gap: got %b expected %b", Busy, 1'b0); end
        tick();
        vectors++; if (Grant !== 4'b0010) begin miscompares++; $display("FAIL t4_second_grant: got %b expected %b", Grant, 4'b0010); end
        tick();
        vectors++; if (Ack !== 4'b0010) begin miscompares++; $display("FAIL t4_second_ack: got %b expected %b", Ack, 4'b0010); end
        Req = 4'b0000;
        tick();
        RdAddr = 3'd4;
        #1;
        vectors++; if (RdData !== 8'h44) begin miscompares++; $display("FAIL t4_bank4: got %h expected %h", RdData, 8'h44); end
        RdAddr = 3'd6;
        #1;
        vectors++; if (RdData !== 8'h77) begin miscompares++; $display("FAIL t4_bank6_last_wins: got %h expected %h", RdData, 8'h77); end
    endtask

    task automatic test_abort();
        apply_reset();
        set_fields(3, 3'd3, 8'h99);
        set_fields(0, 3'd2, 8'h22);
        RdAddr = 3'd3;
        Req = 4'b1000;
        tick();
        vectors++; if (Grant !== 4'b1000) begin miscompares++; $display("FAIL t5_grant3: got %b expected %b", Grant, 4'b1000); end
        Req = 4'b0000;
        tick();
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL t5_abort_busy: got %b expected %b", Busy, 1'b0); end
        vectors++; if (Grant !== 4'b0000) begin miscompares++; $display("FAIL t5_abort_grant: got %b expected %b", Grant, 4'b0000); end
        vectors++; if (Ack !== 4'b0000) begin miscompares++; $display("FAIL t5_abort_ack: got %b expected %b", Ack, 4'b0000); end
        tick();
        vectors++; if (Ack !== 4'b0000) begin miscompares++; $display("FAIL t5_abort_ack_late: got %b expected %b", Ack, 4'b0000); end
        vectors++; if (RdData !== 8'h00) begin miscompares++; $display("FAIL t5_bank3_unchanged: got %h expected %h", RdData, 8'h00); end
        Req = 4'b0001;
        tick();
        Req = 4'b0000;
        tick();
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL t5_abort0_busy: got %b expected %b", Busy, 1'b0); end
        Req = 4'b1001;
        tick();
        vectors++; if (Grant !== 4'b0001) begin miscompares++; $display("FAIL t5_ptr_kept: got %b expected %b", Grant, 4'b0001); end
        tick();
        Req = 4'b1000;
        tick();
        tick();
        vectors++; if (Grant !== 4'b1000) begin miscompares++; $display("FAIL t5_then_grant3: got %b expected %b", Grant, 4'b1000); end
        tick();
        Req = 4'b0000;
        tick();
        RdAddr = 3'd2;
        #1;
        vectors++; if (RdData !== 8'h22) begin miscompares++; $display("FAIL t5_bank2: got %h expected %h", RdData, 8'h22); end
        RdAddr = 3'd3;
        #1;
        vectors++; if (RdData !== 8'h99) begin miscompares++; $display("FAIL t5_bank3: got %h expected %h", RdData, 8'h99); end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        set_fields(0, 3'd7, 8'h3C);
        RdAddr = 3'd7;
        Req = 4'b0001;
        tick();
        tick();
        vectors++; if (Ack !== 4'b0001) begin miscompares++; $display("FAIL t6_in_write: got %b expected %b", Ack, 4'b0001); end
        Resetn = 1'b0;
        #1;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL t6_busy_async: got %b expected %b", Busy, 1'b0); end
        vectors++; if (Ack !== 4'b0000) begin miscompares++; $display("FAIL t6_ack_async: got %b expected %b", Ack, 4'b0000); end
        vectors++; if (Grant !== 4'b0000) begin miscompares++; $display("FAIL t6_grant_async: got %b expected %b", Grant, 4'b0000); end
        Req = 4'b0000;
        tick();
        Resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (Ack !== 4'b0000) begin miscompares++; $display("FAIL t6_no_ack[%0d]: got %b expected %b", c, Ack, 4'b0000); end
        end
        vectors++; if (RdData !== 8'h00) begin miscompares++; $display("FAIL t6_bank7: got %h expected %h", RdData, 8'h00); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Resetn      = 1'b0;
        Req         = 4'b0000;
        WrAddr      = 12'h000;
        WrData      = 32'h0000_0000;
        RdAddr      = 3'd0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_priority();
        test_abort();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
